// File: rtl/axis_depacketizer_player.sv
// axis_depacketizer_player
// Accepts one TLAST-framed packet of up to SMPLS samples on an AXI4-Stream
// slave, buffers it, then plays it out on an AXI4-Stream master at one
// sample every PERIOD = ACLK/FSMPL clocks. `interrupt` is high while the
// block waits for the next packet.
//
// Handshakes: a beat transfers on a rising clock edge where tvalid and
// tready are both high. The master holds tdata/tlast stable while tvalid
// is high and not yet accepted. Playout is not stalled by the sink: a
// sample still pending at its successor's tick is dropped (late_err).
//
// Optional feature macro: DEPKT_ERR_CNT_EN adds the saturating err_cnt
// output counting over-length packets and dropped late samples.
module axis_depacketizer_player #(
  parameter int ACLK       = 100_000_000,
  parameter int FSMPL      = 200,
  parameter int SMPLS      = 30,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  interrupt,
  output logic                  pkt_err,
`ifdef DEPKT_ERR_CNT_EN
  output logic [7:0]            err_cnt,
`endif
  output logic                  late_err
);

  localparam int PERIOD = ACLK / FSMPL;
  localparam int CW     = $clog2(SMPLS + 1);
  localparam int PW     = $clog2(PERIOD);
  localparam int AW     = (SMPLS > 1) ? $clog2(SMPLS) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(SMPLS - 1);
  localparam logic [CW-1:0] C_FULL = CW'(SMPLS);
  localparam logic [PW-1:0] P_LAST = PW'(PERIOD - 1);

  typedef enum logic [1:0] {
    ST_RX    = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_s_tready;
  logic                  r_irq;
  logic [CW-1:0]         r_wr_cnt;
  logic [CW-1:0]         r_rd_cnt;
  logic [CW-1:0]         r_len;
  logic [PW-1:0]         r_pcnt;
  logic                  r_m_tvalid;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_m_tlast;
  logic                  r_pkt_err;
  logic                  r_late_err;
  logic [DATA_WIDTH-1:0] r_buf [SMPLS];

  logic          w_s_fire;
  logic          w_m_fire;
  logic          w_tick;
  logic          w_end;
  logic          w_late_drop;
  logic          w_pkt_ovf;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  assign w_s_fire    = s_axis_tvalid & r_s_tready;
  assign w_m_fire    = r_m_tvalid & m_axis_tready;
  // A tick is every cycle in PLAY where the period counter is at zero.
  assign w_tick      = (r_state == ST_PLAY) && (r_pcnt == '0);
  // Last cycle of PLAY: all samples issued and the final period elapsed.
  assign w_end       = (r_state == ST_PLAY) && (r_pcnt == P_LAST) && (r_rd_cnt == r_len);
  // A pending sample not taken on its last chance cycle is lost.
  assign w_late_drop = r_m_tvalid & ~m_axis_tready & (w_tick | w_end);
  assign w_pkt_ovf   = (r_state == ST_RX) && w_s_fire && !s_axis_tlast && (r_wr_cnt == C_LAST);
  assign w_wr_idx    = r_wr_cnt[AW-1:0];
  assign w_rd_idx    = r_rd_cnt[AW-1:0];

  // Sample buffer: only RX beats are stored; contents need no reset.
  always_ff @(posedge aclk) begin
    if (w_s_fire && (r_state == ST_RX)) begin
      r_buf[w_wr_idx] <= s_axis_tdata;
    end
  end

  // Control FSM with registered stream, interrupt and error outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state    <= ST_RX;
      r_s_tready <= 1'b0;
      r_irq      <= 1'b0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_len      <= '0;
      r_pcnt     <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
      r_pkt_err  <= 1'b0;
      r_late_err <= 1'b0;
    end else begin
      if (w_late_drop) begin
        r_late_err <= 1'b1;
      end
      case (r_state)
        ST_RX: begin
          r_s_tready <= 1'b1;
          r_irq      <= 1'b1;
          if (w_s_fire) begin
            r_wr_cnt <= r_wr_cnt + CW'(1);
            if (s_axis_tlast) begin
              r_len      <= r_wr_cnt + CW'(1);
              r_state    <= ST_PLAY;
              r_s_tready <= 1'b0;
              r_irq      <= 1'b0;
              r_rd_cnt   <= '0;
              r_pcnt     <= '0;
            end else if (r_wr_cnt == C_LAST) begin
              r_len     <= C_FULL;
              r_pkt_err <= 1'b1;
              r_state   <= ST_DRAIN;
              r_irq     <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (w_s_fire && s_axis_tlast) begin
            r_state    <= ST_PLAY;
            r_s_tready <= 1'b0;
            r_rd_cnt   <= '0;
            r_pcnt     <= '0;
          end
        end
        ST_PLAY: begin
          if (w_m_fire) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
          end
          r_pcnt <= (r_pcnt == P_LAST) ? '0 : r_pcnt + PW'(1);
          if (w_tick) begin
            // New sample replaces any pending one (drop flagged above).
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= r_buf[w_rd_idx];
            r_m_tlast  <= (r_rd_cnt == r_len - CW'(1));
            r_rd_cnt   <= r_rd_cnt + CW'(1);
          end else if (w_end) begin
            r_state    <= ST_RX;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_wr_cnt   <= '0;
            r_s_tready <= 1'b1;
            r_irq      <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_RX;
        end
      endcase
    end
  end

`ifdef DEPKT_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  logic [8:0] w_err_sum;

  assign w_err_sum = {1'b0, r_err_cnt} + {8'd0, w_pkt_ovf} + {8'd0, w_late_drop};

  // Saturating error event counter; two events in one cycle add two.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_err_cnt <= '0;
    end else begin
      r_err_cnt <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign s_axis_tready = r_s_tready;
  assign interrupt     = r_irq;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tlast  = r_m_tlast;
  assign pkt_err       = r_pkt_err;
  assign late_err      = r_late_err;

endmodule

// File: tb/tb_axis_depacketizer_player.sv
// Testbench for axis_depacketizer_player (SMPLS=4, PERIOD=10).
// Expected playout is computed from the packet contents and the schedule
// rule "sample k visible from entry+k*P+1 until accepted or its window
// closes", with a queue of expected samples and sticky error models.
module tb_axis_depacketizer_player;

  localparam int DW    = 16;
  localparam int SMPLS = 4;
  localparam int ACLK  = 100;
  localparam int FSMPL = 10;
  localparam int P     = ACLK / FSMPL;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          interrupt;
  logic          pkt_err;
  logic          late_err;
`ifdef DEPKT_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  // Scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fix_d [8];
  bit            exp_pkt  = 0;
  bit            exp_late = 0;
  int            exp_err  = 0;
  int            total    = 0;
  int            bad      = 0;

  axis_depacketizer_player #(
    .ACLK(ACLK), .FSMPL(FSMPL), .SMPLS(SMPLS), .DATA_WIDTH(DW)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .interrupt(interrupt),
    .pkt_err(pkt_err),
`ifdef DEPKT_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .late_err(late_err)
  );

  // Clock / watchdog
  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Driver: present n beats with random idle gaps, checking RX/DRAIN outputs.
  task automatic send_pkt(input int n, input int max_gap, input bit use_fixed);
    int i = 0;
    int gaps = 0;
    bit idle;
    logic [DW-1:0] d = '0;
    while (i < n) begin
      idle = (max_gap > 0) && (gaps < max_gap) && ($urandom_range(0, 1) == 1);
      total++;
      if (s_axis_tready !== 1'b1) begin
        bad++; $display("FAIL rx_tready beat %0d: got %b want 1", i, s_axis_tready);
      end
      total++;
      if (interrupt !== (i < SMPLS)) begin
        bad++; $display("FAIL rx_irq beat %0d: got %b want %b", i, interrupt, (i < SMPLS));
      end
      total++;
      if (pkt_err !== exp_pkt) begin
        bad++; $display("FAIL rx_pkt_err beat %0d: got %b want %b", i, pkt_err, exp_pkt);
      end
      total++;
      if (m_axis_tvalid !== 1'b0) begin
        bad++; $display("FAIL rx_m_tvalid beat %0d: got %b want 0", i, m_axis_tvalid);
      end
      if (idle) begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = DW'($urandom);
        s_axis_tlast  = 1'($urandom_range(0, 1));
        gaps++;
      end else begin
        d = use_fixed ? fix_d[i] : DW'($urandom);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = (i == n - 1);
        gaps = 0;
      end
      step();
      if (!idle) begin
        if (i < SMPLS) exp_q.push_back(d);
        if (i == SMPLS - 1 && n > SMPLS) begin
          exp_pkt = 1;
          exp_err++;
        end
        i++;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  // Playout check from PLAY entry (obs 0) through the first RX cycle.
  task automatic run_play(input int len, input int stall_mask, input bit rand_rdy);
    bit got = 0;
    bit exp_v;
    bit exp_l;
    bit rdy;
    int k;
    int e_k;
    logic [DW-1:0] tmp;
    for (int j = 0; j <= len * P; j++) begin
      k = (j >= 1) ? (j - 1) / P : 0;
      if (j >= 1 && j < len * P && ((j - 1) % P) == 0) got = 0;
      exp_v = (j >= 1) && (j < len * P) && !got;
      exp_l = exp_v && (k == len - 1);
      e_k   = (k < len - 1) ? (k + 1) * P : len * P - 1;
      total++;
      if (m_axis_tvalid !== exp_v) begin
        bad++; $display("FAIL m_tvalid obs %0d: got %b want %b", j, m_axis_tvalid, exp_v);
      end
      if (exp_v) begin
        total++;
        if (m_axis_tdata !== exp_q[0]) begin
          bad++; $display("FAIL m_tdata obs %0d: got %h want %h", j, m_axis_tdata, exp_q[0]);
        end
      end
      total++;
      if (m_axis_tlast !== exp_l) begin
        bad++; $display("FAIL m_tlast obs %0d: got %b want %b", j, m_axis_tlast, exp_l);
      end
      total++;
      if (late_err !== exp_late) begin
        bad++; $display("FAIL late_err obs %0d: got %b want %b", j, late_err, exp_late);
      end
      total++;
      if (pkt_err !== exp_pkt) begin
        bad++; $display("FAIL play_pkt_err obs %0d: got %b want %b", j, pkt_err, exp_pkt);
      end
      total++;
      if (interrupt !== (j == len * P)) begin
        bad++; $display("FAIL play_irq obs %0d: got %b want %b", j, interrupt, (j == len * P));
      end
      total++;
      if (s_axis_tready !== (j == len * P)) begin
        bad++; $display("FAIL play_tready obs %0d: got %b want %b", j, s_axis_tready, (j == len * P));
      end
`ifdef DEPKT_ERR_CNT_EN
      total++;
      if (err_cnt !== 8'((exp_err > 255) ? 255 : exp_err)) begin
        bad++; $display("FAIL err_cnt obs %0d: got %0d want %0d", j, err_cnt, exp_err);
      end
`endif
      if (j == len * P) begin
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        break;
      end
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : !(((stall_mask >> k) & 1) == 1);
      m_axis_tready = rdy;
      if (exp_v && rdy) got = 1;
      if (j >= 1 && j == e_k) begin
        tmp = exp_q.pop_front();
        if (!got) begin
          exp_late = 1;
          exp_err++;
        end
      end
      // Garbage on the slave side must be ignored while playing.
      s_axis_tvalid = 1'($urandom_range(0, 1));
      s_axis_tdata  = DW'($urandom);
      s_axis_tlast  = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) step();
    total++;
    if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL rst_tready: got %b want 0", s_axis_tready); end
    total++;
    if (interrupt !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b want 0", interrupt); end
    total++;
    if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_m_tvalid: got %b want 0", m_axis_tvalid); end
    total++;
    if (m_axis_tdata !== '0) begin bad++; $display("FAIL rst_m_tdata: got %h want 0", m_axis_tdata); end
    total++;
    if (m_axis_tlast !== 1'b0) begin bad++; $display("FAIL rst_m_tlast: got %b want 0", m_axis_tlast); end
    total++;
    if (pkt_err !== 1'b0 || late_err !== 1'b0) begin
      bad++; $display("FAIL rst_flags: got %b%b want 00", pkt_err, late_err);
    end
    areset = 1'b0;
    step();
    total++;
    if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL rst_rel_tready: got %b want 1", s_axis_tready); end
    total++;
    if (interrupt !== 1'b1) begin bad++; $display("FAIL rst_rel_irq: got %b want 1", interrupt); end
  endtask

  task automatic test_basic();
    fix_d[0] = 16'h0011; fix_d[1] = 16'h0022; fix_d[2] = 16'h0033; fix_d[3] = 16'h0044;
    send_pkt(4, 0, 1);
    run_play(4, 0, 0);
  endtask

  task automatic test_short();
    fix_d[0] = 16'h000A; fix_d[1] = 16'h000B;
    send_pkt(2, 0, 1);
    run_play(2, 0, 0);
  endtask

  task automatic test_overlength();
    send_pkt(6, 0, 0);
    run_play(SMPLS, 0, 0);
  endtask

  task automatic test_late();
    send_pkt(4, 0, 0);
    run_play(4, 4'b0010, 0);
    send_pkt(3, 1, 0);
    run_play(3, 4'b0100, 0);
  endtask

  task automatic test_rand_rx();
    int n;
    for (int p = 0; p < 6; p++) begin
      n = $urandom_range(1, 6);
      send_pkt(n, 3, 0);
      run_play((n > SMPLS) ? SMPLS : n, int'($urandom_range(0, 15)), (p % 2) == 1);
    end
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 3; p++) begin
      send_pkt(p + 2, 0, 0);
      run_play(((p + 2) > SMPLS) ? SMPLS : p + 2, 0, 0);
    end
  endtask

  task automatic test_reset_mid_play();
    logic [DW-1:0] s1;
    send_pkt(4, 0, 0);
    s1 = exp_q[1];
    m_axis_tready = 1'b1;
    repeat (P + 1) step();
    total++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== s1) begin
      bad++; $display("FAIL mid_sample2: got %b/%h want 1/%h", m_axis_tvalid, m_axis_tdata, s1);
    end
    areset = 1'b1;
    step();
    exp_q.delete();
    exp_pkt = 0; exp_late = 0; exp_err = 0;
    total++;
    if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_tvalid: got %b want 0", m_axis_tvalid); end
    total++;
    if (pkt_err !== 1'b0 || late_err !== 1'b0) begin
      bad++; $display("FAIL mid_rst_flags: got %b%b want 00", pkt_err, late_err);
    end
`ifdef DEPKT_ERR_CNT_EN
    total++;
    if (err_cnt !== 8'd0) begin bad++; $display("FAIL mid_rst_err_cnt: got %0d want 0", err_cnt); end
`endif
    areset = 1'b0;
    step();
    total++;
    if (s_axis_tready !== 1'b1 || interrupt !== 1'b1) begin
      bad++; $display("FAIL mid_rst_release: got %b%b want 11", s_axis_tready, interrupt);
    end
    send_pkt(3, 2, 0);
    run_play(3, 0, 0);
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_basic();
    test_short();
    test_overlength();
    test_late();
    test_rand_rx();
    test_back_to_back();
    test_reset_mid_play();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
